recovery_executor: RTL and testbench

RECOVERY_EXECUTOR -- requirements
Module: recovery_executor

---
 rtl/i3c_pkg.sv | 32 +++
 rtl/recovery_executor.sv | 193 +++++++++++++++++++
 tb/tb_recovery_executor.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_pkg.sv
// Shared definitions for the recovery-mode command executor:
// executor state encoding and the supported-command response-length table.
package i3c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DRAIN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_TX_LEN_L,
    ST_TX_LEN_H,
    ST_TX_DATA,
    ST_DONE
  } exec_state_e;

  // Response byte length per command code; 0 marks an unsupported command.
  function automatic logic [7:0] resp_len(input logic [7:0] cmd);
    logic [7:0] len;
    case (cmd)
      8'h26:   len = 8'd8;
      8'h8B:   len = 8'd2;
      8'h8C:   len = 8'd3;
      8'h8D:   len = 8'd6;
      8'h8E:   len = 8'd1;
      8'h8F:   len = 8'd1;
      8'h90:   len = 8'd2;
      default: len = 8'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/recovery_executor.sv
// Recovery-mode command executor: drains write payloads into a register
// window and streams length-prefixed read responses byte by byte.
module recovery_executor
  import i3c_pkg::*;
#(
  parameter int unsigned MaxWords = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         cmd_valid_i,
  input  logic                         cmd_is_rd_i,
  input  logic [7:0]                   cmd_cmd_i,
  input  logic [15:0]                  cmd_len_i,
  input  logic                         cmd_error_i,
  output logic                         cmd_done_o,
  input  logic                         rx_valid_i,
  output logic                         rx_ready_o,
  input  logic [31:0]                  rx_data_i,
  output logic                         reg_wr_o,
  output logic                         reg_rd_o,
  output logic [7:0]                   reg_cmd_o,
  output logic [$clog2(MaxWords)-1:0]  reg_idx_o,
  output logic [31:0]                  reg_wdata_o,
  input  logic [31:0]                  reg_rdata_i,
  output logic                         tx_valid_o,
  input  logic                         tx_ready_i,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_last_o,
  output logic [7:0]                   pec_err_cnt_o,
  output logic [7:0]                   unsup_cnt_o
);

  localparam int unsigned IdxW = $clog2(MaxWords);
  localparam logic [15:0] MaxIdx = 16'(MaxWords);

  exec_state_e state_q, state_d;
  logic [14:0] words_q, words_d;
  logic [15:0] idx_q, idx_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  pec_q, pec_d;
  logic [7:0]  unsup_q, unsup_d;

  logic [7:0]  new_len;
  logic [16:0] len_plus3;

  assign new_len   = resp_len(cmd_cmd_i);
  assign len_plus3 = {1'b0, cmd_len_i} + 17'd3;

  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    idx_d       = idx_q;
    wr_en_d     = wr_en_q;
    cmd_d       = cmd_q;
    rem_d       = rem_q;
    bsel_d      = bsel_q;
    rdata_d     = rdata_q;
    pec_d       = pec_q;
    unsup_d     = unsup_q;
    cmd_done_o  = 1'b0;
    rx_ready_o  = 1'b0;
    reg_wr_o    = 1'b0;
    reg_rd_o    = 1'b0;
    reg_wdata_o = '0;
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    tx_last_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d  = cmd_cmd_i;
          idx_d  = '0;
          bsel_d = '0;
          // PEC error takes precedence: such a command is never counted as unsupported.
          if (cmd_error_i) begin
            pec_d = (pec_q == 8'hFF) ? pec_q : pec_q + 8'd1;
          end else if (new_len == 8'd0) begin
            unsup_d = (unsup_q == 8'hFF) ? unsup_q : unsup_q + 8'd1;
          end
          if (!cmd_is_rd_i) begin
            words_d = len_plus3[16:2];
            wr_en_d = !cmd_error_i && (new_len != 8'd0);
            state_d = (len_plus3[16:2] == 15'd0) ? ST_DONE : ST_WR_DRAIN;
          end else begin
            rem_d   = new_len;
            state_d = (cmd_error_i || new_len == 8'd0) ? ST_DONE : ST_TX_LEN_L;
          end
        end
      end
      ST_WR_DRAIN: begin
        rx_ready_o  = 1'b1;
        reg_wdata_o = rx_data_i;
        if (rx_valid_i) begin
          reg_wr_o = wr_en_q && (idx_q < MaxIdx);
          idx_d    = idx_q + 16'd1;
          words_d  = words_q - 15'd1;
          if (words_q == 15'd1) state_d = ST_DONE;
        end
      end
      ST_TX_LEN_L: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rem_q;
        if (tx_ready_i) state_d = ST_TX_LEN_H;
      end
      ST_TX_LEN_H: begin
        tx_valid_o = 1'b1;
        if (tx_ready_i) state_d = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        reg_rd_o = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rdata_d = reg_rdata_i;
        bsel_d  = '0;
        state_d = ST_TX_DATA;
      end
      ST_TX_DATA: begin
        tx_valid_o = 1'b1;
        tx_data_o  = rdata_q[{bsel_q, 3'b000} +: 8];
        tx_last_o  = (rem_q == 8'd1);
        if (tx_ready_i) begin
          rem_d  = rem_q - 8'd1;
          bsel_d = bsel_q + 2'd1;
          if (rem_q == 8'd1) begin
            state_d = ST_DONE;
          end else if (bsel_q == 2'd3) begin
            idx_d   = idx_q + 16'd1;
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_DONE: begin
        cmd_done_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable overrides everything above while keeping the counters untouched.
    if (!enable_i) begin
      state_d     = ST_IDLE;
      pec_d       = pec_q;
      unsup_d     = unsup_q;
      cmd_done_o  = 1'b0;
      rx_ready_o  = 1'b0;
      reg_wr_o    = 1'b0;
      reg_rd_o    = 1'b0;
      reg_wdata_o = '0;
      tx_valid_o  = 1'b0;
      tx_data_o   = '0;
      tx_last_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      words_q <= '0;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      cmd_q   <= '0;
      rem_q   <= '0;
      bsel_q  <= '0;
      rdata_q <= '0;
      pec_q   <= '0;
      unsup_q <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      cmd_q   <= cmd_d;
      rem_q   <= rem_d;
      bsel_q  <= bsel_d;
      rdata_q <= rdata_d;
      pec_q   <= pec_d;
      unsup_q <= unsup_d;
    end
  end

  assign reg_cmd_o     = cmd_q;
  assign reg_idx_o     = idx_q[IdxW-1:0];
  assign pec_err_cnt_o = pec_q;
  assign unsup_cnt_o   = unsup_q;

endmodule

// File: tb/tb_recovery_executor.sv
// Randomized bench for recovery_executor against a transaction-level model
// of expected register writes, response bytes and error counters.
module tb_recovery_executor;

  localparam int unsigned MW = 4;
  localparam int unsigned IW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, enable_i;
  logic          cmd_valid_i, cmd_is_rd_i, cmd_error_i;
  logic [7:0]    cmd_cmd_i;
  logic [15:0]   cmd_len_i;
  logic          cmd_done_o;
  logic          rx_valid_i, rx_ready_o;
  logic [31:0]   rx_data_i;
  logic          reg_wr_o, reg_rd_o;
  logic [7:0]    reg_cmd_o;
  logic [IW-1:0] reg_idx_o;
  logic [31:0]   reg_wdata_o, reg_rdata_i;
  logic          tx_valid_o, tx_ready_i, tx_last_o;
  logic [7:0]    tx_data_o;
  logic [7:0]    pec_err_cnt_o, unsup_cnt_o;

  recovery_executor #(.MaxWords(MW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .cmd_valid_i(cmd_valid_i), .cmd_is_rd_i(cmd_is_rd_i), .cmd_cmd_i(cmd_cmd_i),
    .cmd_len_i(cmd_len_i), .cmd_error_i(cmd_error_i), .cmd_done_o(cmd_done_o),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
    .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_cmd_o(reg_cmd_o),
    .reg_idx_o(reg_idx_o), .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
    .tx_last_o(tx_last_o), .pec_err_cnt_o(pec_err_cnt_o), .unsup_cnt_o(unsup_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  int          m_pec = 0;
  int          m_unsup = 0;
  logic [31:0] rd_mem [MW];
  logic [31:0] wbuf [$];
  bit          stall_en = 0;

  function automatic int exp_resp_len(input logic [7:0] cmd);
    case (cmd)
      8'h26: return 8;
      8'h8B: return 2;
      8'h8C: return 3;
      8'h8D: return 6;
      8'h8E: return 1;
      8'h8F: return 1;
      8'h90: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Observation queues filled by the monitor
  logic [8:0]  tx_q [$];
  logic [23:0] wr_id_q [$];
  logic [31:0] wr_data_q [$];
  int          done_cnt = 0;
  int          pop_cnt = 0;
  bit          prev_hold = 0;
  logic [8:0]  prev_tx;
  bit          rd_pend = 0;
  logic [IW-1:0] rd_idx;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (prev_hold && enable_i)
        check_eq("tx_hold", {23'd0, tx_valid_o, tx_last_o, tx_data_o}, {23'd0, 1'b1, prev_tx});
      prev_hold = tx_valid_o && !tx_ready_i && enable_i;
      prev_tx   = {tx_last_o, tx_data_o};
      if (tx_valid_o && tx_ready_i) tx_q.push_back({tx_last_o, tx_data_o});
      if (reg_wr_o) begin
        wr_id_q.push_back({reg_cmd_o, 16'(reg_idx_o)});
        wr_data_q.push_back(reg_wdata_o);
      end
      if (rx_valid_i && rx_ready_o) pop_cnt++;
      if (cmd_done_o) done_cnt++;
    end else begin
      prev_hold = 0;
    end
    // Register-read responder: data appears only in the cycle after the strobe.
    if (reg_rd_o) begin
      rd_pend     = 1;
      rd_idx      = reg_idx_o;
      reg_rdata_i = $urandom;
    end else if (rd_pend) begin
      reg_rdata_i = rd_mem[rd_idx];
      rd_pend     = 0;
    end
  end

  task automatic send_cmd(input bit rd, input logic [7:0] cmd, input logic [15:0] len, input bit err);
    @(posedge clk_i); #1;
    cmd_valid_i = 1; cmd_is_rd_i = rd; cmd_cmd_i = cmd; cmd_len_i = len; cmd_error_i = err;
    @(posedge clk_i); #1;
    cmd_valid_i = 0; cmd_is_rd_i = $urandom; cmd_cmd_i = $urandom; cmd_len_i = $urandom; cmd_error_i = $urandom;
  endtask

  task automatic model_count(input logic [7:0] cmd, input bit err);
    if (err) m_pec = sat(m_pec);
    else if (exp_resp_len(cmd) == 0) m_unsup = sat(m_unsup);
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_pec"}, {24'd0, pec_err_cnt_o}, m_pec);
    check_eq({tag, "_unsup"}, {24'd0, unsup_cnt_o}, m_unsup);
  endtask

  task automatic do_write(input string tag, input logic [7:0] cmd, input logic [15:0] len,
                          input bit err, input bit fixed);
    int nw, base, cyc;
    bit sup;
    logic [23:0] e_id [$];
    logic [31:0] e_data [$];
    nw  = (int'(len) + 3) / 4;
    sup = exp_resp_len(cmd) != 0;
    if (!fixed) begin
      wbuf.delete();
      for (int k = 0; k < nw; k++) wbuf.push_back($urandom);
    end
    for (int k = 0; k < nw; k++)
      if (!err && sup && k < int'(MW)) begin
        e_id.push_back({cmd, 16'(k)});
        e_data.push_back(wbuf[k]);
      end
    model_count(cmd, err);
    wr_id_q.delete(); wr_data_q.delete(); tx_q.delete();
    pop_cnt = 0; base = done_cnt;
    send_cmd(0, cmd, len, err);
    cyc = 0;
    while (done_cnt == base && cyc < 4000) begin
      rx_valid_i = ($urandom_range(3) != 0) && (pop_cnt < nw);
      rx_data_i  = (pop_cnt < nw) ? wbuf[pop_cnt] : $urandom;
      @(posedge clk_i); #1;
      cyc++;
    end
    rx_valid_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq({tag, "_done"}, done_cnt - base, 1);
    check_eq({tag, "_pops"}, pop_cnt, nw);
    check_eq({tag, "_nwr"}, wr_id_q.size(), e_id.size());
    for (int k = 0; k < e_id.size() && k < wr_id_q.size(); k++) begin
      check_eq({tag, "_wr_cmd_idx"}, {8'd0, wr_id_q[k]}, {8'd0, e_id[k]});
      check_eq({tag, "_wr_data"}, wr_data_q[k], e_data[k]);
    end
    check_eq({tag, "_no_tx"}, tx_q.size(), 0);
    check_counters(tag);
  endtask

  task automatic do_read(input string tag, input logic [7:0] cmd, input bit err, input bit stall);
    int rl, base, cyc;
    logic [8:0] e_tx [$];
    logic [31:0] wv;
    rl = exp_resp_len(cmd);
    if (!err && rl != 0) begin
      e_tx.push_back({1'b0, 8'(rl)});
      e_tx.push_back(9'h000);
      for (int i = 0; i < rl; i++) begin
        wv = rd_mem[i / 4];
        e_tx.push_back({i == rl - 1, wv[8 * (i % 4) +: 8]});
      end
    end
    model_count(cmd, err);
    wr_id_q.delete(); wr_data_q.delete(); tx_q.delete();
    base = done_cnt;
    stall_en = stall;
    send_cmd(1, cmd, 0, err);
    cyc = 0;
    while (done_cnt == base && cyc < 4000) begin
      tx_ready_i = stall_en ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk_i); #1;
      cyc++;
    end
    tx_ready_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq({tag, "_done"}, done_cnt - base, 1);
    check_eq({tag, "_ntx"}, tx_q.size(), e_tx.size());
    for (int k = 0; k < e_tx.size() && k < tx_q.size(); k++)
      check_eq({tag, "_tx_byte"}, {23'd0, tx_q[k]}, {23'd0, e_tx[k]});
    check_eq({tag, "_no_wr"}, wr_id_q.size(), 0);
    check_counters(tag);
  endtask

  task automatic wait_tx_bytes(input int n);
    int cyc = 0;
    while (tx_q.size() < n && cyc < 200) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check_eq("wait_tx_bytes", tx_q.size() >= n, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] cmd_list [9] = '{8'h26, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F, 8'h90, 8'h55, 8'hFF};

  initial begin
    rst_i = 1; enable_i = 1; cmd_valid_i = 0; cmd_is_rd_i = 0; cmd_cmd_i = 0;
    cmd_len_i = 0; cmd_error_i = 0; rx_valid_i = 0; rx_data_i = 0;
    reg_rdata_i = 0; tx_ready_i = 1;
    for (int i = 0; i < int'(MW); i++) rd_mem[i] = $urandom;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 0;
    @(negedge clk_i);
    check_eq("rst_tx_valid", tx_valid_o, 0);
    check_eq("rst_done", cmd_done_o, 0);
    check_eq("rst_strobes", {rx_ready_o, reg_wr_o, reg_rd_o}, 0);
    check_eq("rst_idx_cmd", {reg_cmd_o, 6'd0, reg_idx_o}, 0);
    check_counters("rst");

    wbuf = '{32'h11223344, 32'h55667788};
    do_write("wr_basic", 8'h26, 16'd8, 0, 1);
    do_write("wr_pec", 8'h26, 16'd5, 1, 0);

    rd_mem[0] = 32'hDDCCBBAA; rd_mem[1] = 32'h0000FFEE;
    do_read("rd_basic", 8'h8D, 0, 0);
    do_read("rd_stall", 8'h8D, 0, 1);

    // Unsupported read: done pulse in the cycle right after acceptance.
    tx_q.delete();
    send_cmd(1, 8'hFF, 0, 0);
    m_unsup = sat(m_unsup);
    @(negedge clk_i);
    check_eq("unsup_done_pulse", cmd_done_o, 1);
    @(negedge clk_i);
    check_eq("unsup_done_once", cmd_done_o, 0);
    check_eq("unsup_no_tx", tx_q.size(), 0);
    check_counters("unsup_rd");

    do_write("wr_window_edge", 8'h8E, 16'd20, 0, 0);
    do_write("wr_unsup", 8'h55, 16'd8, 0, 0);
    do_write("wr_len0", 8'h8B, 16'd0, 0, 0);
    do_read("rd_pec", 8'h8D, 1, 0);
    do_read("rd_one", 8'h8E, 0, 1);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] c;
      bit e;
      c = cmd_list[$urandom_range(8)];
      e = ($urandom_range(4) == 0);
      for (int i = 0; i < int'(MW); i++) rd_mem[i] = $urandom;
      if ($urandom_range(1) == 1) do_read("rd_rand", c, e, 1'($urandom_range(1)));
      else do_write("wr_rand", c, 16'($urandom_range(24)), e, 0);
    end

    // Disable mid-response: outputs drop, counters hold, command is abandoned.
    for (int i = 0; i < int'(MW); i++) rd_mem[i] = $urandom;
    tx_q.delete();
    tx_ready_i = 1;
    send_cmd(1, 8'h8D, 0, 0);
    wait_tx_bytes(3);
    enable_i = 0;
    @(negedge clk_i);
    check_eq("dis_tx_valid", tx_valid_o, 0);
    check_counters("dis");
    @(posedge clk_i); #1 enable_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("dis_idle_no_tx", tx_valid_o, 0);
    do_read("rd_after_dis", 8'h8D, 0, 1);

    for (int t = 0; t < 260; t++) begin
      send_cmd(1, 8'hFF, 0, 0);
      m_unsup = sat(m_unsup);
    end
    for (int t = 0; t < 3; t++) begin
      send_cmd(0, 8'h26, 0, 1);
      m_pec = sat(m_pec);
    end
    repeat (2) @(posedge clk_i);
    #1;
    check_counters("sat");

    // Reset in the middle of the data phase, then a clean read.
    tx_q.delete();
    send_cmd(1, 8'h8D, 0, 0);
    wait_tx_bytes(3);
    rst_i = 1;
    @(posedge clk_i); #1 rst_i = 0;
    m_pec = 0; m_unsup = 0;
    @(negedge clk_i);
    check_eq("rst_mid_tx_valid", tx_valid_o, 0);
    check_eq("rst_mid_done", cmd_done_o, 0);
    check_counters("rst_mid");
    for (int i = 0; i < int'(MW); i++) rd_mem[i] = $urandom;
    do_read("rd_after_rst", 8'h8D, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
